// File: rtl/cr16_ctrl_pkg.sv
// Shared definitions for the CR16 multicycle control FSM: states, opcode and
// extension fields, condition codes, PSR bit positions and result-mux codes.
package cr16_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        LOAD   = 3'd3,
        STORE  = 3'd4,
        JUMP   = 3'd5
    } state_t;

    // Primary opcodes, instr[15:12]
    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_ANDI    = 4'b0001;
    localparam logic [3:0] OP_ORI     = 4'b0010;
    localparam logic [3:0] OP_XORI    = 4'b0011;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_ADDI    = 4'b0101;
    localparam logic [3:0] OP_SHIFT   = 4'b1000;
    localparam logic [3:0] OP_SUBI    = 4'b1001;
    localparam logic [3:0] OP_CMPI    = 4'b1011;
    localparam logic [3:0] OP_BCOND   = 4'b1100;
    localparam logic [3:0] OP_MOVI    = 4'b1101;
    localparam logic [3:0] OP_LUI     = 4'b1111;

    // Extension codes under OP_SPECIAL, instr[7:4]
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // ALU codes that update flags (shared by R-type ext and immediate op)
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1011;

    // Condition codes, instr[11:8]
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // PSR bit indices
    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    // choose_result encodings
    localparam logic [1:0] CR_SHIFT = 2'b00;
    localparam logic [1:0] CR_ALU   = 2'b01;
    localparam logic [1:0] CR_PCALU = 2'b10;
    localparam logic [1:0] CR_LINK  = 2'b11;

    // ADD/SUB/CMP forms write the PSR
    function automatic logic is_flag_op(input logic [3:0] code);
        return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_CMP);
    endfunction

    // Logical immediates and LUI take a zero-extended immediate
    function automatic logic is_zext_op(input logic [3:0] code);
        return (code == OP_ANDI) || (code == OP_ORI) ||
               (code == OP_XORI) || (code == OP_LUI);
    endfunction

endpackage

// File: rtl/cr16_control_fsm_cond_check.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the PSR
// flags to a single taken bit.
module cond_check
    import cr16_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [7:0] psr,
    output logic       taken
);

    logic c_s, l_s, f_s, z_s, n_s;
    logic unused_flags;

    assign c_s = psr[PSR_C];
    assign l_s = psr[PSR_L];
    assign f_s = psr[PSR_F];
    assign z_s = psr[PSR_Z];
    assign n_s = psr[PSR_N];
    assign unused_flags = ^{psr[4:3], psr[1]};

    // Condition decode; code 1111 is never taken
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = z_s;
            CC_NE:   taken = ~z_s;
            CC_CS:   taken = c_s;
            CC_CC:   taken = ~c_s;
            CC_HI:   taken = l_s;
            CC_LS:   taken = ~l_s;
            CC_GT:   taken = n_s;
            CC_LE:   taken = ~n_s;
            CC_FS:   taken = f_s;
            CC_FC:   taken = ~f_s;
            CC_LO:   taken = ~l_s & ~z_s;
            CC_HS:   taken = l_s | z_s;
            CC_LT:   taken = ~n_s & ~z_s;
            CC_GE:   taken = n_s | z_s;
            CC_UC:   taken = 1'b1;
            CC_NV:   taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_control_fsm.sv
// CR16 multicycle control FSM. Sequences fetch, decode, execute, memory and
// writeback for the RF/ALU datapath. Outputs are decoded from the current
// state and gated by instr, psr and mem_ready; illegal is a sticky register.
module cr16_control_fsm
    import cr16_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   instr,
    input  logic [7:0]         psr,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               ir_en,
    output logic               reg_we,
    output logic               psr_en,
    output logic               next_instruction,
    output logic               mem_rd,
    output logic               mem_we,
    output logic               write_data,
    output logic               store_reg,
    output logic               zero_extend,
    output logic               src_b,
    output logic               shift_type,
    output logic [REGBITS-1:0] alu_cond,
    output logic               jmp_en,
    output logic               branch_en,
    output logic               jal_en,
    output logic [1:0]         choose_result,
    output logic               illegal
);

    logic [3:0] op_s, cond_s, ext_s, alu_code_s;
    logic       taken_s;
    logic       set_illegal_s;
    logic       unused_instr;
    state_t     state_r, state_next_s;
    logic       illegal_r;

    assign op_s         = instr[15:12];
    assign cond_s       = instr[11:8];
    assign ext_s        = instr[7:4];
    assign alu_code_s   = (op_s == OP_RTYPE) ? ext_s : op_s;
    assign unused_instr = ^instr[3:0];
    assign illegal      = illegal_r;

    cond_check u_cond_check (
        .cond  (cond_s),
        .psr   (psr),
        .taken (taken_s)
    );

    // State register and sticky illegal-instruction flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (set_illegal_s) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Next-state and datapath control decode; all strobes forced low in reset
    always_comb begin
        state_next_s     = state_r;
        set_illegal_s    = 1'b0;
        pc_en            = 1'b0;
        ir_en            = 1'b0;
        reg_we           = 1'b0;
        psr_en           = 1'b0;
        next_instruction = 1'b0;
        mem_rd           = 1'b0;
        mem_we           = 1'b0;
        write_data       = 1'b1;
        store_reg        = 1'b0;
        zero_extend      = 1'b0;
        src_b            = 1'b0;
        shift_type       = 1'b0;
        alu_cond         = '0;
        jmp_en           = 1'b0;
        branch_en        = 1'b0;
        jal_en           = 1'b0;
        choose_result    = CR_ALU;

        if (reset) begin
            state_next_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    next_instruction = 1'b1;
                    mem_rd           = 1'b1;
                    if (mem_ready) begin
                        ir_en        = 1'b1;
                        state_next_s = DECODE;
                    end else begin
                        state_next_s = FETCH;
                    end
                end

                DECODE: begin
                    case (op_s)
                        OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
                        OP_SUBI, OP_CMPI, OP_MOVI, OP_LUI, OP_SHIFT:
                            state_next_s = EXEC;
                        OP_SPECIAL: begin
                            case (ext_s)
                                EXT_LOAD:           state_next_s = LOAD;
                                EXT_STOR:           state_next_s = STORE;
                                EXT_JAL, EXT_JCOND: state_next_s = JUMP;
                                default: begin
                                    set_illegal_s = 1'b1;
                                    pc_en         = 1'b1;
                                    state_next_s  = FETCH;
                                end
                            endcase
                        end
                        OP_BCOND:
                            state_next_s = JUMP;
                        default: begin
                            set_illegal_s = 1'b1;
                            pc_en         = 1'b1;
                            state_next_s  = FETCH;
                        end
                    endcase
                end

                EXEC: begin
                    pc_en        = 1'b1;
                    reg_we       = 1'b1;
                    state_next_s = FETCH;
                    if (op_s == OP_SHIFT) begin
                        choose_result = CR_SHIFT;
                        src_b         = 1'b0;
                    end else if (op_s == OP_RTYPE) begin
                        alu_cond = REGBITS'(alu_code_s);
                        src_b    = 1'b0;
                        psr_en   = is_flag_op(alu_code_s);
                        reg_we   = (alu_code_s != ALU_CMP);
                    end else begin
                        alu_cond    = REGBITS'(alu_code_s);
                        src_b       = 1'b1;
                        zero_extend = is_zext_op(op_s);
                        psr_en      = is_flag_op(alu_code_s);
                        reg_we      = (alu_code_s != ALU_CMP);
                    end
                end

                LOAD: begin
                    next_instruction = 1'b0;
                    mem_rd           = 1'b1;
                    if (mem_ready) begin
                        reg_we       = 1'b1;
                        write_data   = 1'b0;
                        pc_en        = 1'b1;
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = LOAD;
                    end
                end

                STORE: begin
                    next_instruction = 1'b0;
                    store_reg        = 1'b1;
                    mem_we           = 1'b1;
                    if (mem_ready) begin
                        pc_en        = 1'b1;
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = STORE;
                    end
                end

                JUMP: begin
                    pc_en         = 1'b1;
                    choose_result = CR_PCALU;
                    state_next_s  = FETCH;
                    if ((op_s == OP_SPECIAL) && (ext_s == EXT_JAL)) begin
                        jal_en        = 1'b1;
                        jmp_en        = 1'b1;
                        reg_we        = 1'b1;
                        choose_result = CR_LINK;
                    end else if (op_s == OP_SPECIAL) begin
                        jmp_en = taken_s;
                    end else begin
                        branch_en = taken_s;
                    end
                end

                default: begin
                    state_next_s = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed bench for cr16_control_fsm. Each step drives inputs, pushes the
// expected control word onto a scoreboard, and a negedge checker pops and
// compares it against the DUT outputs under a per-step care mask.
module tb_cr16_control_fsm;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic [7:0]  psr;
    logic        mem_ready;
    logic        pc_en, ir_en, reg_we, psr_en, next_instruction, mem_rd, mem_we;
    logic        write_data, store_reg, zero_extend, src_b, shift_type;
    logic [3:0]  alu_cond;
    logic        jmp_en, branch_en, jal_en;
    logic [1:0]  choose_result;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    // Enable/strobe bits (always compared)
    localparam logic [9:0] E_PC = 10'h200, E_IR = 10'h100, E_RW = 10'h080,
                           E_PS = 10'h040, E_MR = 10'h020, E_MW = 10'h010,
                           E_JE = 10'h008, E_BE = 10'h004, E_JL = 10'h002,
                           E_IL = 10'h001, E_NONE = 10'h000;
    // Select bits: [11]next_instruction [10]write_data [9]store_reg
    // [8]zero_extend [7]src_b [6]shift_type [5:2]alu_cond [1:0]choose_result
    localparam logic [11:0] S_NI = 12'h800, S_WD = 12'h400, S_SR = 12'h200,
                            S_ZE = 12'h100, S_SB = 12'h080, S_ST = 12'h040,
                            S_AC = 12'h03C, S_CR = 12'h003, S_NONE = 12'h000;

    typedef struct {
        string       tag;
        logic [21:0] val;
        logic [21:0] mask;
    } exp_t;

    exp_t        sb_q[$];
    logic [21:0] obs;

    assign obs = {pc_en, ir_en, reg_we, psr_en, mem_rd, mem_we, jmp_en,
                  branch_en, jal_en, illegal, next_instruction, write_data,
                  store_reg, zero_extend, src_b, shift_type, alu_cond,
                  choose_result};

    cr16_control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr            (instr),
        .psr              (psr),
        .mem_ready        (mem_ready),
        .pc_en            (pc_en),
        .ir_en            (ir_en),
        .reg_we           (reg_we),
        .psr_en           (psr_en),
        .next_instruction (next_instruction),
        .mem_rd           (mem_rd),
        .mem_we           (mem_we),
        .write_data       (write_data),
        .store_reg        (store_reg),
        .zero_extend      (zero_extend),
        .src_b            (src_b),
        .shift_type       (shift_type),
        .alu_cond         (alu_cond),
        .jmp_en           (jmp_en),
        .branch_en        (branch_en),
        .jal_en           (jal_en),
        .choose_result    (choose_result),
        .illegal          (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ac(input logic [3:0] code);
        return {6'b000000, code, 2'b00};
    endfunction

    // Scoreboard consumer: compare one expected word per cycle mid-period
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            assert ((obs & e.mask) === (e.val & e.mask)) else begin
                errors++;
                $error("FAIL %s: observed %06h expected %06h (care %06h)",
                       e.tag, obs & e.mask, e.val & e.mask, e.mask);
            end
        end
    end

    task automatic step(input string tag, input logic [9:0] en,
                        input logic [11:0] sel, input logic [11:0] smask);
        exp_t e;
        e.tag  = tag;
        e.val  = {en, sel};
        e.mask = {10'h3FF, smask | S_ST};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Fetch (zero-wait) then decode for the instruction currently on instr
    task automatic fetch_decode(input string tag, input logic [9:0] il);
        step({tag, "_fetch"}, E_IR | E_MR | il, S_NI, S_NI);
        step({tag, "_decode"}, il, S_NONE, S_NONE);
    endtask

    initial begin
        reset     = 1'b1;
        instr     = 16'h0000;
        psr       = 8'h00;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset_outputs", E_NONE, S_NONE, S_NONE);

        // ADD R1,R2
        reset     = 1'b0;
        mem_ready = 1'b0;
        instr     = 16'h0152;
        step("fetch_wait", E_MR, S_NI, S_NI);
        mem_ready = 1'b1;
        fetch_decode("add", E_NONE);
        step("add_exec", E_PC | E_RW | E_PS, ac(4'b0101) | 12'h001,
             S_SB | S_AC | S_CR);

        // LOAD with two wait cycles
        instr = 16'h4102;
        fetch_decode("ld", E_NONE);
        mem_ready = 1'b0;
        step("ld_wait1", E_MR, S_NONE, S_NI);
        step("ld_wait2", E_MR, S_NONE, S_NI);
        mem_ready = 1'b1;
        step("ld_done", E_MR | E_RW | E_PC, S_NONE, S_NI | S_WD);

        // BEQ taken / not taken
        instr = 16'hC005;
        psr   = 8'h40;
        fetch_decode("beq_t", E_NONE);
        step("beq_taken", E_PC | E_BE, S_NONE, S_NONE);
        psr = 8'h00;
        fetch_decode("beq_n", E_NONE);
        step("beq_not_taken", E_PC, S_NONE, S_NONE);

        // JAL, unconditional and never jumps
        instr = 16'h4E83;
        fetch_decode("jal", E_NONE);
        step("jal_exec", E_PC | E_JE | E_JL | E_RW, 12'h003, S_CR);
        instr = 16'h4EC3;
        fetch_decode("juc", E_NONE);
        step("juc_taken", E_PC | E_JE, S_NONE, S_NONE);
        instr = 16'h4FC3;
        fetch_decode("jnv", E_NONE);
        step("jnv_not_taken", E_PC, S_NONE, S_NONE);

        // BLO: !L & !Z
        instr = 16'hCA05;
        psr   = 8'h00;
        fetch_decode("blo_t", E_NONE);
        step("blo_taken", E_PC | E_BE, S_NONE, S_NONE);
        psr = 8'h04;
        fetch_decode("blo_n", E_NONE);
        step("blo_not_taken", E_PC, S_NONE, S_NONE);

        // STORE zero-wait, then STORE abandoned by reset
        instr = 16'h4142;
        fetch_decode("st", E_NONE);
        step("st_done", E_MW | E_PC, S_SR, S_SR | S_NI);
        fetch_decode("st_rst", E_NONE);
        mem_ready = 1'b0;
        step("st_wait", E_MW, S_SR, S_SR | S_NI);
        reset     = 1'b1;
        mem_ready = 1'b1;
        step("st_reset", E_NONE, S_NONE, S_NONE);
        reset     = 1'b0;
        mem_ready = 1'b0;
        step("after_reset_fetch", E_MR, S_NI, S_NI);
        mem_ready = 1'b1;

        // Undefined opcode, then normal flow with illegal sticky
        instr = 16'h7000;
        step("ill_fetch", E_IR | E_MR, S_NI, S_NI);
        step("ill_decode", E_PC, S_NONE, S_NONE);
        instr = 16'h1125;
        fetch_decode("andi", E_IL);
        step("andi_exec", E_PC | E_RW | E_IL, S_ZE | S_SB | ac(4'b0001) | 12'h001,
             S_ZE | S_SB | S_AC | S_CR);
        instr = 16'hB1F0;
        fetch_decode("cmpi", E_IL);
        step("cmpi_exec", E_PC | E_PS | E_IL, S_SB | ac(4'b1011),
             S_ZE | S_SB | S_AC);
        instr = 16'h8104;
        fetch_decode("shift", E_IL);
        step("shift_exec", E_PC | E_RW | E_IL, S_NONE, S_CR);
        instr = 16'h01B2;
        fetch_decode("cmp", E_IL);
        step("cmp_exec", E_PC | E_PS | E_IL, ac(4'b1011), S_SB | S_AC);

        // Reset clears illegal on the following edge
        reset = 1'b1;
        step("reset_illegal_held", E_IL, S_NONE, S_NONE);
        reset = 1'b0;
        step("illegal_cleared", E_IR | E_MR, S_NI, S_NI);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0",
                   sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
